video_mnist_class_vote: RTL and testbench

- Receiving end of the MNIST CNN core's output AXI4-Stream; one beat per pixel, each beat a per-pixel class vector.
- Accumulates per-class pixel votes over one video frame (delimited by tuser[0] start-of-frame).
- At each frame boundary, snapshots the counts, scans them sequentially for the maximum, and emits a one-cycle frame result: winning class and its vote count.
- Sits directly after the validation core, feeding a register block or overlay logic.

---
 rtl/video_mnist_class_vote_pkg.sv | 26 ++
 rtl/video_mnist_class_vote_argmax.sv | 100 ++++++++++
 rtl/video_mnist_class_vote.sv | 92 +++++++++
 tb/tb_video_mnist_class_vote.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/video_mnist_class_vote_pkg.sv
// Shared types and helpers for the per-frame MNIST class vote.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package video_mnist_class_vote_pkg;

  // Class-index width for a given number of classes (at least one bit)
  function automatic int class_width(input int num_class);
    return (num_class > 1) ? $clog2(num_class) : 1;
  endfunction

  localparam int NUM_CLASS_DEFAULT   = 10;
  localparam int CLASS_WIDTH_DEFAULT = class_width(NUM_CLASS_DEFAULT);

  // Argmax scan sequencing
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_t;

  // Increment that sticks at max_v instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/video_mnist_class_vote_argmax.sv
// Sequential strict-greater argmax over a snapshot of per-class vote counts.
// Latency: done pulse appears NUM_CLASS+1 edges after the start edge.
// Backpressure: none; start is only honoured in IDLE, busy tells the caller to hold off.
module video_mnist_class_vote_argmax
  import video_mnist_class_vote_pkg::*;
#(
  parameter int NUM_CLASS   = 10,
  parameter int COUNT_WIDTH = 20,
  parameter int CLASS_WIDTH = class_width(NUM_CLASS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [NUM_CLASS*COUNT_WIDTH-1:0] shadow_load,
  output logic                             busy,
  output logic [CLASS_WIDTH-1:0]           res_class,
  output logic [COUNT_WIDTH-1:0]           res_count,
  output logic                             res_done,
  output logic [15:0]                      frame_num
);

  localparam logic [CLASS_WIDTH-1:0] LAST_IDX = CLASS_WIDTH'(NUM_CLASS - 1);

  scan_state_t state, state_nxt;
  logic [COUNT_WIDTH-1:0] shadow [NUM_CLASS];
  logic [CLASS_WIDTH-1:0] idx;
  logic [CLASS_WIDTH-1:0] best;
  logic [COUNT_WIDTH-1:0] best_cnt;
  logic                   load;
  logic                   scan_step;
  logic                   finish;

  assign busy = (state != ST_IDLE);
  assign load = start && (state == ST_IDLE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: one class compared per edge, then a single publish edge
  always_comb begin
    state_nxt = state;
    scan_step = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        scan_step = 1'b1;
        if (idx == LAST_IDX) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        finish    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Snapshot load, running maximum (ties keep the lower index) and result publish
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CLASS; i++) shadow[i] <= '0;
      idx       <= '0;
      best      <= '0;
      best_cnt  <= '0;
      res_class <= '0;
      res_count <= '0;
      res_done  <= 1'b0;
      frame_num <= '0;
    end else begin
      res_done <= finish;
      if (load) begin
        for (int i = 0; i < NUM_CLASS; i++) shadow[i] <= shadow_load[i*COUNT_WIDTH +: COUNT_WIDTH];
        idx      <= '0;
        best     <= '0;
        best_cnt <= '0;
      end
      if (scan_step) begin
        if (shadow[idx] > best_cnt) begin
          best     <= idx;
          best_cnt <= shadow[idx];
        end
        idx <= idx + 1'b1;
      end
      if (finish) begin
        res_class <= best;
        res_count <= best_cnt;
        frame_num <= frame_num + 16'd1;
      end
    end
  end

endmodule

// File: rtl/video_mnist_class_vote.sv
// Per-frame class vote: counts per-pixel class bits, reports the winning class at each SOF.
// Latency: m_valid high in the cycle after edge NUM_CLASS+1 following the SOF accept edge.
// Backpressure: tready drops only for a SOF beat while a scan is in flight; other beats always accepted.
module video_mnist_class_vote
  import video_mnist_class_vote_pkg::*;
#(
  parameter int TUSER_WIDTH = 1,
  parameter int NUM_CLASS   = 10,
  parameter int COUNT_WIDTH = 20,
  parameter int CLASS_WIDTH = class_width(NUM_CLASS)
) (
  input  logic                   reset,
  input  logic                   clk,
  input  logic [TUSER_WIDTH-1:0] s_axi4s_tuser,
  input  logic                   s_axi4s_tlast,
  input  logic [NUM_CLASS-1:0]   s_axi4s_tdata,
  input  logic                   s_axi4s_tvalid,
  output logic                   s_axi4s_tready,
  output logic [CLASS_WIDTH-1:0] m_class,
  output logic [COUNT_WIDTH-1:0] m_count,
  output logic                   m_valid,
  output logic [15:0]            m_frame_num
);

  localparam logic [31:0] CNT_MAX = (32'd1 << COUNT_WIDTH) - 32'd1;

  logic [COUNT_WIDTH-1:0]           cnt     [NUM_CLASS];
  logic [COUNT_WIDTH-1:0]           cnt_inc [NUM_CLASS];
  logic [NUM_CLASS-1:0][31:0]       inc_wide;
  logic [NUM_CLASS*COUNT_WIDTH-1:0] cnt_flat;
  logic                             started;
  logic                             busy;
  logic                             sof;
  logic                             accept;
  logic                             snap;
  logic                             unused_ok;

  assign sof            = s_axi4s_tuser[0];
  assign s_axi4s_tready = !(busy && s_axi4s_tvalid && sof);
  assign accept         = s_axi4s_tvalid && s_axi4s_tready;
  assign snap           = accept && sof && started;

  // Line boundaries and the upper bits of the wide increment carry no information here
  assign unused_ok = ^{s_axi4s_tlast, s_axi4s_tuser, inc_wide};

  for (genvar g = 0; g < NUM_CLASS; g++) begin : g_flat
    assign cnt_flat[g*COUNT_WIDTH +: COUNT_WIDTH] = cnt[g];
  end

  // Saturating next value for every live counter
  always_comb begin
    for (int i = 0; i < NUM_CLASS; i++) begin
      inc_wide[i] = sat_inc(32'(cnt[i]), CNT_MAX);
      cnt_inc[i]  = inc_wide[i][COUNT_WIDTH-1:0];
    end
  end

  // Live vote counters: SOF reloads from the SOF pixel, other beats add; nothing counts before the first SOF
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      started <= 1'b0;
      for (int i = 0; i < NUM_CLASS; i++) cnt[i] <= '0;
    end else if (accept) begin
      if (sof) begin
        started <= 1'b1;
        for (int i = 0; i < NUM_CLASS; i++) cnt[i] <= COUNT_WIDTH'(s_axi4s_tdata[i]);
      end else if (started) begin
        for (int i = 0; i < NUM_CLASS; i++) begin
          if (s_axi4s_tdata[i]) cnt[i] <= cnt_inc[i];
        end
      end
    end
  end

  // The scanner owns its own shadow bank, so live counting continues during a scan
  video_mnist_class_vote_argmax #(
    .NUM_CLASS   (NUM_CLASS),
    .COUNT_WIDTH (COUNT_WIDTH),
    .CLASS_WIDTH (CLASS_WIDTH)
  ) u_argmax (
    .clk         (clk),
    .reset       (reset),
    .start       (snap),
    .shadow_load (cnt_flat),
    .busy        (busy),
    .res_class   (m_class),
    .res_count   (m_count),
    .res_done    (m_valid),
    .frame_num   (m_frame_num)
  );

endmodule

// File: tb/tb_video_mnist_class_vote.sv
module tb_video_mnist_class_vote;

  localparam int NC   = 10;
  localparam int CW_A = 20;
  localparam int CW_B = 4;

  typedef struct {
    int     cls;
    int     cnt;
    int     fnum;
    longint cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [0:0]      tuser = '0;
  logic            tlast = 1'b0;
  logic            tvalid = 1'b0;
  logic [NC-1:0]   tdata = '0;
  logic            rdy_a, rdy_b;
  logic [3:0]      cls_a, cls_b;
  logic [CW_A-1:0] cnt_a;
  logic [CW_B-1:0] cnt_b;
  logic            v_a, v_b;
  logic [15:0]     fn_a, fn_b;

  always #5 clk = ~clk;

  video_mnist_class_vote #(.TUSER_WIDTH(1), .NUM_CLASS(NC), .COUNT_WIDTH(CW_A), .CLASS_WIDTH(4)) dut_a (
    .reset(reset), .clk(clk), .s_axi4s_tuser(tuser), .s_axi4s_tlast(tlast), .s_axi4s_tdata(tdata),
    .s_axi4s_tvalid(tvalid), .s_axi4s_tready(rdy_a), .m_class(cls_a), .m_count(cnt_a),
    .m_valid(v_a), .m_frame_num(fn_a));

  video_mnist_class_vote #(.TUSER_WIDTH(1), .NUM_CLASS(NC), .COUNT_WIDTH(CW_B), .CLASS_WIDTH(4)) dut_b (
    .reset(reset), .clk(clk), .s_axi4s_tuser(tuser), .s_axi4s_tlast(tlast), .s_axi4s_tdata(tdata),
    .s_axi4s_tvalid(tvalid), .s_axi4s_tready(rdy_b), .m_class(cls_b), .m_count(cnt_b),
    .m_valid(v_b), .m_frame_num(fn_b));

  exp_t   qa[$];
  exp_t   qb[$];
  int     n_checks = 0;
  int     n_fail = 0;
  longint cyc = 0;

  // Reference model state
  int     live[NC];
  bit     started;
  int     frame_num;
  bit     scan_act;
  longint scan_e0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit model_busy();
    return scan_act && ((cyc - scan_e0) <= NC);
  endfunction

  function automatic exp_t winner(input int maxv, input longint vcyc);
    exp_t e;
    int v;
    e.cls = 0;
    e.cnt = 0;
    for (int i = 0; i < NC; i++) begin
      v = (live[i] > maxv) ? maxv : live[i];
      if (v > e.cnt) begin
        e.cls = i;
        e.cnt = v;
      end
    end
    e.fnum = frame_num & 32'hFFFF;
    e.cyc  = vcyc;
    return e;
  endfunction

  // Called just before the edge on which the beat is accepted
  task automatic model_accept(input bit sof, input logic [NC-1:0] d);
    if (sof) begin
      if (started) begin
        frame_num++;
        qa.push_back(winner((1 << CW_A) - 1, cyc + 1 + NC + 1));
        qb.push_back(winner((1 << CW_B) - 1, cyc + 1 + NC + 1));
        scan_act = 1'b1;
        scan_e0  = cyc + 1;
      end
      for (int i = 0; i < NC; i++) live[i] = int'(d[i]);
      started = 1'b1;
    end else if (started) begin
      for (int i = 0; i < NC; i++) live[i] += int'(d[i]);
    end
  endtask

  task automatic model_clear();
    qa.delete();
    qb.delete();
    started   = 1'b0;
    scan_act  = 1'b0;
    frame_num = 0;
    for (int i = 0; i < NC; i++) live[i] = 0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset  = 1'b1;
    tvalid = 1'b0;
    tuser  = '0;
    model_clear();
    repeat (n) @(negedge clk);
    check("rst_valid_a", v_a, 0);
    check("rst_class_a", cls_a, 0);
    check("rst_count_a", cnt_a, 0);
    check("rst_frame_a", fn_a, 0);
    check("rst_tready_a", rdy_a, 1);
    check("rst_valid_b", v_b, 0);
    check("rst_count_b", cnt_b, 0);
    check("rst_frame_b", fn_b, 0);
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      tvalid = 1'b0;
      tuser  = '0;
    end
  endtask

  task automatic drive_beat(input bit sof, input logic [NC-1:0] d);
    int tries;
    bit done;
    tries = 0;
    done  = 1'b0;
    @(negedge clk);
    tvalid = 1'b1;
    tuser  = sof;
    tdata  = d;
    tlast  = 1'($urandom_range(0, 1));
    while (!done) begin
      #1;
      check("tready_a", rdy_a, !(sof && model_busy()));
      check("tready_b", rdy_b, !(sof && model_busy()));
      if (rdy_a) begin
        model_accept(sof, d);
        done = 1'b1;
      end else if (tries >= 40) begin
        n_checks++;
        n_fail++;
        $display("FAIL sof_stall_timeout: still stalled after %0d cycles, expected acceptance", tries);
        done = 1'b1;
      end else begin
        tries++;
        @(negedge clk);
      end
    end
  endtask

  // First beat (SOF) and the next na-1 beats carry da, then nb beats carry db
  task automatic frame_two(input logic [NC-1:0] da, input int na,
                           input logic [NC-1:0] db, input int nb, input int gap_max);
    for (int k = 0; k < na + nb; k++) begin
      drive_beat(k == 0, (k < na) ? da : db);
      if (gap_max > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, gap_max));
    end
  endtask

  task automatic rand_frame(input int len);
    logic [NC-1:0] d;
    for (int k = 0; k < len; k++) begin
      d = NC'($urandom & $urandom);
      drive_beat(k == 0, d);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
  endtask

  // Scoreboard monitor: pops one expectation per m_valid cycle
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (v_a) begin
        if (qa.size() == 0) begin
          check("unexpected_valid_a", v_a, 0);
        end else begin
          e = qa.pop_front();
          check("class_a", cls_a, e.cls);
          check("count_a", cnt_a, e.cnt);
          check("frame_a", fn_a, e.fnum);
          check("latency_a", cyc, e.cyc);
        end
      end
      if (v_b) begin
        if (qb.size() == 0) begin
          check("unexpected_valid_b", v_b, 0);
        end else begin
          e = qb.pop_front();
          check("class_b", cls_b, e.cls);
          check("count_b", cnt_b, e.cnt);
          check("frame_b", fn_b, e.fnum);
          check("latency_b", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    do_reset(2);

    // Pre-SOF beats must not count
    for (int k = 0; k < 3; k++) drive_beat(1'b0, 10'h040);
    // Frame A: class 3 x60, class 7 x40
    frame_two(10'h008, 60, 10'h080, 40, 3);
    // Tie frame: class 2 x50, class 5 x50 (its SOF reports frame A)
    frame_two(10'h004, 50, 10'h020, 50, 2);
    // Multi-hot frame
    frame_two(10'h3FF, 20, 10'h000, 0, 2);
    // SOF pixel alone votes class 9
    frame_two(10'h200, 1, 10'h000, 5, 0);
    // Three-beat frame: next SOF stalls behind the running scan
    frame_two(10'h001, 1, 10'h001, 2, 0);
    // Saturation frame for the narrow counter
    frame_two(10'h002, 20, 10'h000, 0, 0);
    // Randomized frames, some shorter than the scan
    for (int f = 0; f < 8; f++) rand_frame($urandom_range(1, 40));

    // Reset during a scan: the pending result is dropped
    drive_beat(1'b1, 10'h001);
    idle(4);
    do_reset(2);
    @(negedge clk);
    check("post_rst_valid_a", v_a, 0);
    check("post_rst_frame_a", fn_a, 0);
    for (int k = 0; k < 5; k++) drive_beat(1'b0, 10'h040);
    frame_two(10'h004, 1, 10'h004, 3, 0);
    frame_two(10'h001, 1, 10'h000, 0, 0);

    idle(30);
    check("pending_a", qa.size(), 0);
    check("pending_b", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
